// File: rtl/pacemaker_pkg.sv
// Shared types, default timing and configuration legality check for the
// dual-chamber pace scheduler.
package pacemaker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VA   = 2'd1,
    S_AV   = 2'd2,
    S_URW  = 2'd3
  } pace_state_t;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_LRI_CYC   = 100;
  localparam int DEF_AVI_CYC   = 30;
  localparam int DEF_URI_CYC   = 60;
  localparam int DEF_PVARP_CYC = 25;
  localparam int DEF_VRP_CYC   = 20;

  // AVI must be at least one cycle because the AV compare is against AVI-1.
  function automatic bit cfg_legal(input int cnt_w, input int lri, input int avi,
                                   input int uri, input int pvarp, input int vrp);
    longint lim;
    lim = 64'sd1 << cnt_w;
    cfg_legal = (cnt_w > 1) && (cnt_w < 62) &&
                (avi > 0) && (avi < uri) && (uri <= lri) &&
                (vrp <= pvarp) && (pvarp < lri - avi) &&
                (longint'(lri) < lim) && (longint'(avi) < lim) &&
                (longint'(uri) < lim) && (longint'(pvarp) < lim) &&
                (longint'(vrp) < lim);
  endfunction

endpackage

// File: rtl/pace_interval_timer.sv
// Saturating up-counter measuring cycles since the last clear event.
module pace_interval_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up, hold at all-ones, restart from zero on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= CNT_ZERO;
    end else if (clr) begin
      cnt <= CNT_ZERO;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/dual_chamber_pace_scheduler.sv
// DDD pacing controller: atrial/ventricular sensing in, one-cycle pace
// pulses out, with lower-rate, AV-delay, upper-rate and refractory timing.
module dual_chamber_pace_scheduler
  import pacemaker_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LRI_CYC   = DEF_LRI_CYC,
  parameter int AVI_CYC   = DEF_AVI_CYC,
  parameter int URI_CYC   = DEF_URI_CYC,
  parameter int PVARP_CYC = DEF_PVARP_CYC,
  parameter int VRP_CYC   = DEF_VRP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sa,
  input  logic       sv,
  output logic       pa,
  output logic       pv,
  output logic       a_refr,
  output logic       v_refr,
  output logic [1:0] state
);

  if (!cfg_legal(CNT_W, LRI_CYC, AVI_CYC, URI_CYC, PVARP_CYC, VRP_CYC)) begin : g_cfg_illegal
    $fatal(1, "dual_chamber_pace_scheduler: illegal timing configuration");
  end

  // Timer compare points; the -1 terms make the pulse appear on the edge
  // where the timer would have reached the nominal value.
  localparam logic [CNT_W-1:0] PA_T    = CNT_W'(LRI_CYC - AVI_CYC - 1);
  localparam logic [CNT_W-1:0] AV_T    = CNT_W'(AVI_CYC - 1);
  localparam logic [CNT_W-1:0] UR_T    = CNT_W'(URI_CYC - 1);
  localparam logic [CNT_W-1:0] PVARP_T = CNT_W'(PVARP_CYC);
  localparam logic [CNT_W-1:0] VRP_T   = CNT_W'(VRP_CYC);

  pace_state_t      state_r;
  pace_state_t      state_nx;
  logic             sa_q_r;
  logic             sv_q_r;
  logic             pa_r;
  logic             pv_r;
  logic             pa_nx;
  logic             pv_nx;
  logic             v_clr;
  logic             a_clr;
  logic             sa_ev;
  logic             sv_ev;
  logic [CNT_W-1:0] t_v;
  logic [CNT_W-1:0] t_av;

  pace_interval_timer #(.CNT_W(CNT_W)) u_t_v (
    .clk (clk),
    .rst (rst),
    .clr (v_clr),
    .cnt (t_v)
  );

  pace_interval_timer #(.CNT_W(CNT_W)) u_t_av (
    .clk (clk),
    .rst (rst),
    .clr (a_clr),
    .cnt (t_av)
  );

  assign sa_ev  = sa & ~sa_q_r;
  assign sv_ev  = sv & ~sv_q_r;
  assign a_refr = (t_v < PVARP_T);
  assign v_refr = (t_v < VRP_T);
  assign pa     = pa_r;
  assign pv     = pv_r;
  assign state  = state_r;

  // Sense edge history, FSM state and registered pace pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa_q_r  <= 1'b0;
      sv_q_r  <= 1'b0;
      pa_r    <= 1'b0;
      pv_r    <= 1'b0;
      state_r <= S_IDLE;
    end else begin
      sa_q_r  <= sa;
      sv_q_r  <= sv;
      pa_r    <= pa_nx;
      pv_r    <= pv_nx;
      state_r <= state_nx;
    end
  end

  // Next state, timer clears and pulse requests; disabling overrides all.
  always_comb begin
    state_nx = state_r;
    pa_nx    = 1'b0;
    pv_nx    = 1'b0;
    v_clr    = 1'b0;
    a_clr    = 1'b0;
    if (!en) begin
      state_nx = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          v_clr    = 1'b1;
          state_nx = S_VA;
        end
        S_VA: begin
          if (sv_ev && !v_refr) begin
            v_clr    = 1'b1;
            state_nx = S_VA;
          end else if (sa_ev && !a_refr) begin
            a_clr    = 1'b1;
            state_nx = S_AV;
          end else if (t_v == PA_T) begin
            pa_nx    = 1'b1;
            a_clr    = 1'b1;
            state_nx = S_AV;
          end else begin
            state_nx = S_VA;
          end
        end
        S_AV: begin
          if (sv_ev && !v_refr) begin
            v_clr    = 1'b1;
            state_nx = S_VA;
          end else if (t_av == AV_T) begin
            if (t_v >= UR_T) begin
              pv_nx    = 1'b1;
              v_clr    = 1'b1;
              state_nx = S_VA;
            end else begin
              state_nx = S_URW;
            end
          end else begin
            state_nx = S_AV;
          end
        end
        S_URW: begin
          if (sv_ev) begin
            v_clr    = 1'b1;
            state_nx = S_VA;
          end else if (t_v == UR_T) begin
            pv_nx    = 1'b1;
            v_clr    = 1'b1;
            state_nx = S_VA;
          end else begin
            state_nx = S_URW;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_chamber_pace_scheduler.sv
// Directed bench: expected pace pulses are queued with their cycle number
// when stimulus is applied and matched as the scheduler emits them.
module tb_dual_chamber_pace_scheduler;

  localparam logic [1:0] K_PA = 2'b10;
  localparam logic [1:0] K_PV = 2'b01;
  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_VA   = 32'd1;
  localparam logic [31:0] ST_AV   = 32'd2;
  localparam logic [31:0] ST_URW  = 32'd3;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sa;
  logic       sv;
  logic       pa;
  logic       pv;
  logic       a_refr;
  logic       v_refr;
  logic [1:0] state;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   b;
  exp_t q[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;

  dual_chamber_pace_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sa     (sa),
    .sv     (sv),
    .pa     (pa),
    .pv     (pv),
    .a_refr (a_refr),
    .v_refr (v_refr),
    .state  (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Every pulse seen must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (pa === 1'b1 || pv === 1'b1)) begin
      check("pa_pv_exclusive", {31'd0, pa & pv}, 32'd0);
      check("no_back_to_back", {31'd0, prev_pulse}, 32'd0);
      check("pulse_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_kind", {30'd0, pa, pv}, {30'd0, mon_e.kind});
      end
    end
    prev_pulse <= pa | pv;
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    sa  = 1'b0;
    sv  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pa", {31'd0, pa}, 32'd0);
    check("rst_pv", {31'd0, pv}, 32'd0);
    check("rst_state", {30'd0, state}, ST_IDLE);
    check("rst_a_refr", {31'd0, a_refr}, 32'd1);
    check("rst_v_refr", {31'd0, v_refr}, 32'd1);
    rst = 1'b1;
    at(cyc + 5);

    // Free-running: pa at t_v=70, pv at t_v=100, period 100.
    en = 1'b1;
    b = cyc + 1;
    push(b + 70, K_PA); push(b + 100, K_PV);
    push(b + 170, K_PA); push(b + 200, K_PV);
    at(b);       check("en_state_va", {30'd0, state}, ST_VA);
    at(b + 19);  check("v_refr_t19", {31'd0, v_refr}, 32'd1);
    at(b + 20);  check("v_refr_t20", {31'd0, v_refr}, 32'd0);
    at(b + 24);  check("a_refr_t24", {31'd0, a_refr}, 32'd1);
    at(b + 25);  check("a_refr_t25", {31'd0, a_refr}, 32'd0);
    at(b + 71);  check("after_pa_av", {30'd0, state}, ST_AV);
    at(b + 200); b = b + 200;
    check("after_pv_va", {30'd0, state}, ST_VA);

    // Sensed atrium at t_v=40: pv 30 cycles after the A event.
    at(b + 40); sa = 1'b1;
    at(b + 41); sa = 1'b0;
    check("sa40_state_av", {30'd0, state}, ST_AV);
    push(b + 71, K_PV);
    at(b + 71); b = b + 71;
    push(b + 70, K_PA); push(b + 100, K_PV);
    at(b + 100); b = b + 100;

    // Upper-rate case: sa at t_v=27, AVI expires at 57, pv held to 60.
    at(b + 27); sa = 1'b1;
    at(b + 28); sa = 1'b0;
    push(b + 60, K_PV);
    at(b + 57); check("ur_state_av", {30'd0, state}, ST_AV);
    at(b + 58); check("ur_state_urw", {30'd0, state}, ST_URW);
    at(b + 60); b = b + 60;
    check("ur_done_va", {30'd0, state}, ST_VA);

    // Refractory senses ignored; sa held high gives no further events.
    push(b + 70, K_PA);  push(b + 100, K_PV);
    push(b + 170, K_PA); push(b + 200, K_PV);
    push(b + 270, K_PA); push(b + 300, K_PV);
    at(b + 10); sa = 1'b1; sv = 1'b1;
    at(b + 11); sv = 1'b0;
    check("refr_state_va", {30'd0, state}, ST_VA);
    at(b + 300); b = b + 300;
    at(b + 10); sa = 1'b0;

    // PVC at t_v=50 restarts the ventricular timer.
    at(b + 50); sv = 1'b1;
    at(b + 51); sv = 1'b0; b = b + 51;
    check("pvc_state_va", {30'd0, state}, ST_VA);
    check("pvc_v_refr", {31'd0, v_refr}, 32'd1);
    push(b + 70, K_PA); push(b + 100, K_PV);
    at(b + 100); b = b + 100;

    // Simultaneous sa+sv: ventricular sense wins.
    at(b + 50); sa = 1'b1; sv = 1'b1;
    at(b + 51); sa = 1'b0; sv = 1'b0; b = b + 51;
    check("sim_state_va", {30'd0, state}, ST_VA);
    push(b + 70, K_PA); push(b + 100, K_PV);

    // Asynchronous reset in S_AV cancels the pending pv.
    at(b + 75);
    check("pre_rst_av", {30'd0, state}, ST_AV);
    rst = 1'b0;
    #1;
    check("arst_pa", {31'd0, pa}, 32'd0);
    check("arst_pv", {31'd0, pv}, 32'd0);
    check("arst_state", {30'd0, state}, ST_IDLE);
    check("arst_a_refr", {31'd0, a_refr}, 32'd1);
    check("arst_v_refr", {31'd0, v_refr}, 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    b = cyc + 1;
    push(b + 70, K_PA); push(b + 100, K_PV);
    at(b + 100); b = b + 100;

    // Disable in S_URW on the edge that would have fired pv.
    at(b + 27); sa = 1'b1;
    at(b + 28); sa = 1'b0;
    at(b + 58); check("dis_state_urw", {30'd0, state}, ST_URW);
    at(b + 59); en = 1'b0;
    at(b + 60);
    check("dis_state_idle", {30'd0, state}, ST_IDLE);
    check("dis_pv_suppressed", {31'd0, pv}, 32'd0);
    at(b + 65); en = 1'b1;
    b = cyc + 1;
    push(b + 70, K_PA); push(b + 100, K_PV);
    at(b + 69); check("reen_state_va", {30'd0, state}, ST_VA);
    at(b + 105);
    check("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_chamber_pace_scheduler.md
Name: dual_chamber_pace_scheduler

Overview:
- DDD-style timing controller for a dual-chamber pacemaker.
- Takes atrial/ventricular sense inputs (sa, sv) and schedules atrial/ventricular pace pulses (pa, pv).
- Timing constraints enforced: lower rate interval, AV delay, upper rate limit, PVARP and VRP blanking.
- Sits between the sense front-end and the pulse drivers; the same top-level drives the existing atrial pacemaker bench signals.

Parameters:
- CNT_W, 16, width of the interval timers.
- LRI_CYC, 100, lower rate interval in clk cycles (V event to next V event).
- AVI_CYC, 30, AV delay in cycles (A event to pv).
- URI_CYC, 60, upper rate interval: minimum cycles V event to pv.
- PVARP_CYC, 25, post-ventricular atrial refractory period: sa ignored while t_v < PVARP_CYC.
- VRP_CYC, 20, ventricular refractory period: sv ignored while t_v < VRP_CYC.
- Legal configuration: AVI_CYC < URI_CYC ≤ LRI_CYC; VRP_CYC ≤ PVARP_CYC < LRI_CYC-AVI_CYC; all values < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Asynchronous assert, active-low.
- en  in  1  pacing enable. Low: hold in S_IDLE.
- sa  in  1  atrial sense, level; an event is a 0→1 transition.
- sv  in  1  ventricular sense, level; an event is a 0→1 transition.
- pa  out  1  atrial pace, one-cycle registered pulse.
- pv  out  1  ventricular pace, one-cycle registered pulse.
- a_refr  out  1  high while t_v < PVARP_CYC.
- v_refr  out  1  high while t_v < VRP_CYC.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst=0): state=S_IDLE; pa=pv=0; t_v=t_av=0; sa/sv edge registers=0; a_refr=v_refr=1.
- Edge detect: sa_q/sv_q registered each cycle. Event = in & ~in_q. A level held high produces exactly one event.
- t_v counts cycles since the last V event (sensed or paced); t_av counts cycles since the last A event. Both saturate at all-ones and never wrap.
- "V event" = clear t_v to 0 on the next edge. "A event" = clear t_av to 0 on the next edge.
- S_IDLE: entered when en=0 or on reset. On the first cycle with en=1: treat as a V event (t_v←0) and go to S_VA. pa=pv=0 throughout.
- S_VA (atrial escape):
  - sv event with t_v ≥ VRP_CYC (PVC): V event, stay in S_VA.
  - Else sa event with t_v ≥ PVARP_CYC: A event, go to S_AV.
  - Else t_v == LRI_CYC-AVI_CYC-1: pa=1 next cycle, A event, go to S_AV.
  - sv takes priority over simultaneous sa; sa is then discarded.
- S_AV (AV delay):
  - sv event with t_v ≥ VRP_CYC: V event, go to S_VA, no pv.
  - t_av == AVI_CYC-1 and t_v ≥ URI_CYC-1: pv=1 next cycle, V event, go to S_VA.
  - t_av == AVI_CYC-1 and t_v < URI_CYC-1: go to S_URW.
  - sa events are ignored in this state.
- S_URW (upper-rate wait):
  - sv event: V event, go to S_VA, no pv.
  - t_v == URI_CYC-1: pv=1 next cycle, V event, go to S_VA.
- Resulting timing: pv fires exactly AVI_CYC cycles after the A event, or at t_v==URI_CYC, whichever is later. With no sensing the period is exactly LRI_CYC cycles and pa fires at t_v==LRI_CYC-AVI_CYC.
- Latency: a sense edge sampled on edge n changes state and clears the timer at edge n+1.
- pa and pv are never high in the same cycle. Neither is high for two consecutive cycles.
- en falling mid-cycle: go to S_IDLE on the next edge; any pulse scheduled for that edge is suppressed.
- rst asserted mid-operation: all outputs go to reset values immediately (asynchronous).

Decomposition:
- Package pacemaker_pkg holds:
  - state enum: S_IDLE=0, S_VA=1, S_AV=2, S_URW=3;
  - default timing constants;
  - an elaboration-time legality check for the parameter constraints.
- Sub-module pace_interval_timer: saturating CNT_W-bit up-counter with synchronous clear and async active-low reset. Instantiated twice (t_v, t_av).

Test Plan:
- No sensing, en=1 after reset: pa at t_v=70, pv 30 cycles later; pattern repeats every 100 cycles; pa/pv never overlap.
- sa rising at t_v=40: no pa that cycle; pv at t_v=71 (AVI=30 after the A event); next pa 70 cycles after pv.
- sa rising at t_v=27 (upper-rate case): AVI expires at t_v=57, state=S_URW, pv at t_v=60 exactly.
- sa at t_v=10 (inside PVARP) and sv at t_v=10 (inside VRP): both ignored; pa still at t_v=70. sa held high 300 cycles yields only one event.
- sv rising at t_v=50 in S_VA: PVC restarts t_v, pa at 70 cycles after the PVC. Simultaneous sa+sv at t_v=50: sv wins, state stays S_VA.
- rst low during S_AV: pa=pv=0 and state=S_IDLE immediately. en low during S_URW: no pv emitted; re-enable restarts with pa 70 cycles later.
